lcd_pixel_prefetch: RTL and testbench

//  Pixel source stage directly upstream of the RGB LCD top; runs in the LCD pixel-clock domain.

---
 rtl/lcd_pixel_prefetch_pkg.sv | 11 +
 rtl/lcd_pixel_prefetch_if.sv | 11 +
 rtl/lcd_pixel_prefetch_ram.sv | 22 ++
 rtl/lcd_pixel_prefetch.sv | 104 ++++++++++
 tb/tb_lcd_pixel_prefetch.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_pixel_prefetch_pkg.sv
// rtl/lcd_pixel_prefetch_pkg.sv - shared constants and state encoding for the LCD pixel prefetch
package lcd_pkg;
   localparam int PIX_W = 16;
   localparam logic [PIX_W-1:0] BG_DEFAULT = 16'h0000;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FLUSH = 2'd1,
      ST_RUN   = 2'd2
   } prefetch_state_t;
endpackage

// File: rtl/lcd_pixel_prefetch_if.sv
// rtl/lcd_pixel_prefetch_if.sv - frame-store source side of the pixel prefetch (stream + refill requests)
interface lcd_pixel_prefetch_if import lcd_pkg::*; #(parameter int DW = PIX_W);
   logic [DW-1:0] in_data;
   logic          in_valid;
   logic          in_ready;
   logic          burst_req;
   logic          frame_req;

   modport master (output in_data, in_valid, input in_ready, burst_req, frame_req);
   modport slave  (input in_data, in_valid, output in_ready, burst_req, frame_req);
endinterface

// File: rtl/lcd_pixel_prefetch_ram.sv
// rtl/lcd_pixel_prefetch_ram.sv - simple dual-port DEPTH x DW RAM with registered read port
module lcd_sync_fifo_ram #(
   parameter int DW    = 16,
   parameter int DEPTH = 512,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic          re,
   input  logic [AW-1:0] rd_addr,
   output logic [DW-1:0] rd_data
);
   logic [DW-1:0] mem [DEPTH];

   // No reset on storage or read register so the array maps onto block RAM.
   always_ff @(posedge clk) begin
      if (we) mem[wr_addr] <= wr_data;
      if (re) rd_data <= mem[rd_addr];
   end
endmodule

// File: rtl/lcd_pixel_prefetch.sv
// rtl/lcd_pixel_prefetch.sv - LCD pixel FIFO with burst refill and frame flush; LCD_PREFETCH_UFCNT_EN adds uf_count
module lcd_pixel_prefetch import lcd_pkg::*; #(
   parameter int            DW       = PIX_W,
   parameter int            DEPTH    = 512,
   parameter int            BURST    = 128,
   parameter logic [DW-1:0] BG_COLOR = BG_DEFAULT
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     lcd_vs,
   input  logic                     rd_en,
   output logic [DW-1:0]            pixel_data,
   output logic [$clog2(DEPTH):0]   fill_level,
   output logic                     underflow,
`ifdef LCD_PREFETCH_UFCNT_EN
   output logic [15:0]              uf_count,
`endif
   lcd_pixel_prefetch_if.slave      src
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] FULL_LVL  = LW'(DEPTH);
   localparam logic [LW-1:0] BURST_THR = LW'(DEPTH - BURST);

   prefetch_state_t state;
   logic            vs_q;
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic            show_ram;
   logic [DW-1:0]   ram_q;
   logic            vs_fall;
   logic            empty;
   logic            full;
   logic            push;
   logic            pop;
   logic            pop_empty;

   assign vs_fall      = vs_q & ~lcd_vs;
   assign empty        = (fill_level == '0);
   assign full         = (fill_level == FULL_LVL);
   assign src.in_ready = !full && !vs_fall && (state != ST_IDLE);
   assign push         = src.in_valid && src.in_ready;
   assign pop          = rd_en && !empty && !vs_fall;
   assign pop_empty    = rd_en && empty && !vs_fall;

   // pixel_data is BG until the first good pop after reset, flush or an underflow.
   assign pixel_data = show_ram ? ram_q : BG_COLOR;

   lcd_sync_fifo_ram #(.DW(DW), .DEPTH(DEPTH)) u_ram (
      .clk     (clk),
      .we      (push),
      .wr_addr (wr_ptr),
      .wr_data (src.in_data),
      .re      (pop),
      .rd_addr (rd_ptr),
      .rd_data (ram_q)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= ST_IDLE;
         vs_q          <= 1'b0;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         fill_level    <= '0;
         show_ram      <= 1'b0;
         underflow     <= 1'b0;
         src.frame_req <= 1'b0;
         src.burst_req <= 1'b1;
      end else begin
         vs_q          <= lcd_vs;
         src.frame_req <= vs_fall;
         src.burst_req <= (state == ST_RUN) && !vs_fall && (fill_level <= BURST_THR);
         if (vs_fall) begin
            state      <= ST_FLUSH;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_level <= '0;
            show_ram   <= 1'b0;
            underflow  <= 1'b0;
         end else begin
            if (state == ST_FLUSH) state <= ST_RUN;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
               rd_ptr   <= rd_ptr + 1'b1;
               show_ram <= 1'b1;
            end else if (pop_empty) begin
               show_ram  <= 1'b0;
               underflow <= 1'b1;
            end
            if (push && !pop)      fill_level <= fill_level + 1'b1;
            else if (pop && !push) fill_level <= fill_level - 1'b1;
         end
      end
   end

`ifdef LCD_PREFETCH_UFCNT_EN
   // Survives frame flushes on purpose: it is a lifetime health counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                   uf_count <= '0;
      else if (pop_empty && uf_count != 16'hFFFF) uf_count <= uf_count + 16'd1;
   end
`endif
endmodule

// File: tb/tb_lcd_pixel_prefetch.sv
// tb/tb_lcd_pixel_prefetch.sv - randomized self-checking bench against a queue model of the prefetch FIFO
module tb_lcd_pixel_prefetch;
   localparam int DEPTH = 512;
   localparam int BURST = 128;
   localparam logic [15:0] BG = 16'h0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        lcd_vs;
   logic        rd_en;
   logic [15:0] pixel_data;
   logic [9:0]  fill_level;
   logic        underflow;
`ifdef LCD_PREFETCH_UFCNT_EN
   logic [15:0] uf_count;
`endif

   lcd_pixel_prefetch_if sif ();

   lcd_pixel_prefetch dut (
      .clk        (clk),
      .rst        (rst),
      .lcd_vs     (lcd_vs),
      .rd_en      (rd_en),
      .pixel_data (pixel_data),
      .fill_level (fill_level),
      .underflow  (underflow),
`ifdef LCD_PREFETCH_UFCNT_EN
      .uf_count   (uf_count),
`endif
      .src        (sif.slave)
   );

   always #5 clk = ~clk;

   logic [15:0] q[$];
   logic [15:0] exp_pix;
   bit          exp_uf, exp_frame, exp_burst, exp_ready, obs_ready, started, vs_prev;
   int          exp_ufc;
   int          total, bad;

   // One clock of the reference model; inputs are set by the caller beforehand.
   task automatic tick();
      bit fall;
      bit burst_next;
      int lvl;
      #1;
      fall       = vs_prev && !lcd_vs;
      lvl        = q.size();
      exp_ready  = started && !fall && (lvl < DEPTH);
      obs_ready  = sif.in_ready;
      burst_next = started && !exp_frame && !fall && (lvl <= DEPTH - BURST);
      if (fall) begin
         q.delete();
         exp_pix = BG;
         exp_uf  = 1'b0;
         started = 1'b1;
      end else begin
         if (rd_en) begin
            if (lvl > 0) exp_pix = q.pop_front();
            else begin
               exp_pix = BG;
               exp_uf  = 1'b1;
               if (exp_ufc < 65535) exp_ufc++;
            end
         end
         if (sif.in_valid && exp_ready) q.push_back(sif.in_data);
      end
      exp_frame = fall;
      exp_burst = burst_next;
      vs_prev   = lcd_vs;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; lcd_vs = 1'b1; rd_en = 1'b0;
      sif.in_valid = 1'b0; sif.in_data = '0;
      q.delete(); started = 0; vs_prev = 0; exp_frame = 0; exp_burst = 1;
      exp_uf = 0; exp_pix = BG; exp_ufc = 0;
      repeat (3) @(posedge clk);
      #1;
      total++; if (pixel_data !== BG) begin bad++; $display("FAIL reset_pixel got=%h want=%h", pixel_data, BG); end
      total++; if (fill_level !== 10'd0) begin bad++; $display("FAIL reset_level got=%0d want=0", fill_level); end
      total++; if (underflow !== 1'b0) begin bad++; $display("FAIL reset_underflow got=%b want=0", underflow); end
      total++; if (sif.frame_req !== 1'b0) begin bad++; $display("FAIL reset_frame_req got=%b want=0", sif.frame_req); end
      total++; if (sif.burst_req !== 1'b1) begin bad++; $display("FAIL reset_burst_req got=%b want=1", sif.burst_req); end
      total++; if (sif.in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", sif.in_ready); end
      rst = 1'b0;
      sif.in_valid = 1'b1; sif.in_data = 16'hDEAD;
      tick();
      total++; if (fill_level !== 10'd0) begin bad++; $display("FAIL idle_push_dropped got=%0d want=0", fill_level); end
      sif.in_valid = 1'b0;
   endtask

   task automatic test_basic();
      logic [15:0] words [4];
      lcd_vs = 1'b1; tick();
      lcd_vs = 1'b0; tick();
      total++; if (sif.frame_req !== 1'b1) begin bad++; $display("FAIL basic_frame_req got=%b want=1", sif.frame_req); end
      tick();
      total++; if (sif.frame_req !== 1'b0) begin bad++; $display("FAIL basic_frame_pulse got=%b want=0", sif.frame_req); end
      for (int i = 0; i < 4; i++) begin
         words[i] = 16'hA100 + 16'(i + 1);
         sif.in_valid = 1'b1; sif.in_data = words[i];
         tick();
      end
      sif.in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         rd_en = 1'b1;
         tick();
         total++; if (pixel_data !== words[i]) begin bad++; $display("FAIL basic_pixel%0d got=%h want=%h", i, pixel_data, words[i]); end
      end
      rd_en = 1'b0;
      total++; if (fill_level !== 10'd0) begin bad++; $display("FAIL basic_level got=%0d want=0", fill_level); end
   endtask

   task automatic test_full();
      sif.in_valid = 1'b1;
      for (int i = 0; i < 700 && q.size() < DEPTH; i++) begin
         sif.in_data = 16'($urandom);
         tick();
         total++; if (sif.burst_req !== exp_burst) begin bad++; $display("FAIL fill_burst lvl=%0d got=%b want=%b", fill_level, sif.burst_req, exp_burst); end
      end
      total++; if (fill_level !== 10'd512) begin bad++; $display("FAIL full_level got=%0d want=512", fill_level); end
      sif.in_data = 16'hBEEF;
      tick();
      total++; if (obs_ready !== 1'b0) begin bad++; $display("FAIL full_in_ready got=%b want=0", obs_ready); end
      total++; if (fill_level !== 10'd512) begin bad++; $display("FAIL full_hold got=%0d want=512", fill_level); end
      rd_en = 1'b1;
      for (int i = 0; i < 16; i++) begin
         sif.in_data = 16'($urandom);
         tick();
         total++; if (pixel_data !== exp_pix) begin bad++; $display("FAIL pushpop_pixel got=%h want=%h", pixel_data, exp_pix); end
         total++; if (fill_level !== 10'(q.size())) begin bad++; $display("FAIL pushpop_level got=%0d want=%0d", fill_level, q.size()); end
      end
      sif.in_valid = 1'b0;
      for (int i = 0; i < 700 && q.size() > 0; i++) begin
         tick();
         total++; if (pixel_data !== exp_pix) begin bad++; $display("FAIL drain_pixel got=%h want=%h", pixel_data, exp_pix); end
         total++; if (sif.burst_req !== exp_burst) begin bad++; $display("FAIL drain_burst lvl=%0d got=%b want=%b", fill_level, sif.burst_req, exp_burst); end
      end
      rd_en = 1'b0;
      total++; if (fill_level !== 10'd0) begin bad++; $display("FAIL drain_level got=%0d want=0", fill_level); end
   endtask

   task automatic test_underflow();
      int base;
      base  = exp_ufc;
      rd_en = 1'b1;
      repeat (3) tick();
      rd_en = 1'b0;
      total++; if (pixel_data !== 16'h0000) begin bad++; $display("FAIL uf_pixel got=%h want=0000", pixel_data); end
      total++; if (underflow !== 1'b1) begin bad++; $display("FAIL uf_flag got=%b want=1", underflow); end
`ifdef LCD_PREFETCH_UFCNT_EN
      total++; if (uf_count !== 16'(base + 3)) begin bad++; $display("FAIL uf_count got=%0d want=%0d", uf_count, base + 3); end
`endif
      sif.in_valid = 1'b1; sif.in_data = 16'h1234; tick();
      sif.in_valid = 1'b0; rd_en = 1'b1; tick(); rd_en = 1'b0;
      total++; if (pixel_data !== 16'h1234) begin bad++; $display("FAIL uf_recover got=%h want=1234", pixel_data); end
      total++; if (underflow !== 1'b1) begin bad++; $display("FAIL uf_sticky got=%b want=1", underflow); end
      lcd_vs = 1'b1; tick();
      lcd_vs = 1'b0; tick();
      total++; if (underflow !== 1'b0) begin bad++; $display("FAIL uf_cleared got=%b want=0", underflow); end
`ifdef LCD_PREFETCH_UFCNT_EN
      total++; if (uf_count !== 16'(base + 3)) begin bad++; $display("FAIL uf_count_flush got=%0d want=%0d", uf_count, base + 3); end
`endif
      tick();
   endtask

   task automatic test_flush_mid();
      lcd_vs = 1'b1;
      sif.in_valid = 1'b1;
      for (int i = 0; i < 400 && q.size() < 300; i++) begin
         sif.in_data = 16'($urandom);
         tick();
      end
      total++; if (fill_level !== 10'd300) begin bad++; $display("FAIL mid_prefill got=%0d want=300", fill_level); end
      lcd_vs = 1'b0;
      tick();
      total++; if (obs_ready !== 1'b0) begin bad++; $display("FAIL mid_in_ready got=%b want=0", obs_ready); end
      total++; if (fill_level !== 10'd0) begin bad++; $display("FAIL mid_level got=%0d want=0", fill_level); end
      total++; if (sif.frame_req !== 1'b1) begin bad++; $display("FAIL mid_frame_req got=%b want=1", sif.frame_req); end
      total++; if (pixel_data !== BG) begin bad++; $display("FAIL mid_pixel got=%h want=%h", pixel_data, BG); end
      sif.in_valid = 1'b0;
      tick();
      total++; if (sif.frame_req !== 1'b0) begin bad++; $display("FAIL mid_frame_pulse got=%b want=0", sif.frame_req); end
   endtask

   task automatic test_random();
      for (int c = 0; c < 4000; c++) begin
         lcd_vs       = ($urandom_range(0, 599) != 0);
         sif.in_valid = ($urandom_range(0, 99) < ((c / 500) % 2 == 0 ? 70 : 35));
         sif.in_data  = 16'($urandom);
         rd_en        = ($urandom_range(0, 99) < 50);
         tick();
         total++; if (obs_ready !== exp_ready) begin bad++; $display("FAIL rnd_in_ready c=%0d got=%b want=%b", c, obs_ready, exp_ready); end
         total++; if (pixel_data !== exp_pix) begin bad++; $display("FAIL rnd_pixel c=%0d got=%h want=%h", c, pixel_data, exp_pix); end
         total++; if (fill_level !== 10'(q.size())) begin bad++; $display("FAIL rnd_level c=%0d got=%0d want=%0d", c, fill_level, q.size()); end
         total++; if (underflow !== exp_uf) begin bad++; $display("FAIL rnd_underflow c=%0d got=%b want=%b", c, underflow, exp_uf); end
         total++; if (sif.frame_req !== exp_frame) begin bad++; $display("FAIL rnd_frame_req c=%0d got=%b want=%b", c, sif.frame_req, exp_frame); end
         total++; if (sif.burst_req !== exp_burst) begin bad++; $display("FAIL rnd_burst_req c=%0d got=%b want=%b", c, sif.burst_req, exp_burst); end
`ifdef LCD_PREFETCH_UFCNT_EN
         total++; if (uf_count !== 16'(exp_ufc)) begin bad++; $display("FAIL rnd_uf_count c=%0d got=%0d want=%0d", c, uf_count, exp_ufc); end
`endif
      end
      rd_en = 1'b0; sif.in_valid = 1'b0; lcd_vs = 1'b1;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_basic();
      test_full();
      test_underflow();
      test_flush_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
